// File: rtl/aim_pkg.sv
// Shared constants and types for the AIM accumulator chain and the stages that
// consume its output.
package aim_pkg;

  localparam int N_FANIN = 20;  // activations per vector (AIM fan-in)
  localparam int SUM_W   = 13;  // signed neuron-sum width
  localparam int ACT_W   = 9;   // signed activation width

  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_e;

  typedef logic [N_FANIN*ACT_W-1:0] act_vec_t;

endpackage

// File: rtl/act_quant.sv
// Combinational requantiser: sign-extend, round half up, arithmetic shift, saturate.
// Define ACT_RELU_EN to clamp negative results to zero.
module act_quant
  import aim_pkg::*;
#(
  parameter int IN_W  = SUM_W,
  parameter int OUT_W = ACT_W,
  parameter int SHIFT = 2
) (
  input  logic signed [IN_W-1:0]  sum,
  output logic signed [OUT_W-1:0] act
);

  // One guard bit so that adding the rounding constant can never wrap.
  localparam int EXT_W = IN_W + 1;
  localparam int MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam int MIN_I = -(1 << (OUT_W - 1));
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(MAX_I);
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(MIN_I);

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;
  logic signed [EXT_W-1:0] sat;

  assign ext = {sum[IN_W-1], sum};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
      assign rounded = ext + HALF;
    end else begin : g_no_round
      assign rounded = ext;
    end
  endgenerate

  assign shifted = rounded >>> SHIFT;

  always_comb begin
    // NOTE: every variable written here gets a value first, so no path can
    // leave it holding its old value (which would infer a latch).
    sat = shifted;
    if (shifted > SAT_MAX) begin
      sat = SAT_MAX;
    end else if (shifted < SAT_MIN) begin
      sat = SAT_MIN;
    end
`ifdef ACT_RELU_EN
    if (sat < 0) begin
      sat = '0;
    end
`endif
    act = OUT_W'(sat);
  end

endmodule

// File: rtl/neuron_act_pack.sv
// Packs requantised neuron sums into N-entry activation vectors with a non-zero
// mask for the next AIM layer. ACT_RELU_EN selects ReLU clamping in act_quant.
module neuron_act_pack
  import aim_pkg::*;
#(
  parameter int N     = N_FANIN,
  parameter int IN_W  = SUM_W,
  parameter int OUT_W = ACT_W,
  parameter int SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] in_sum,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [N*OUT_W-1:0]     act_vec,
  output logic [N-1:0]           nz_mask,
  output logic [4:0]             act_count,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [0:0] ST_FILL = FILL;
  localparam logic [0:0] ST_EMIT = EMIT;

  logic [0:0]              state;
  logic [IDX_W-1:0]        idx;
  logic signed [OUT_W-1:0] q_act;
  logic                    accept;
  logic                    closing;

  act_quant #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_quant (
    .sum(in_sum),
    .act(q_act)
  );

  // Handshake outputs decode straight from the state flop: no input reaches them.
  assign in_ready  = (state == ST_FILL);
  assign out_valid = (state == ST_EMIT);
  assign accept    = in_valid && in_ready;
  assign closing   = in_last || (idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the vector storage is ordinary flops, not a RAM, and must read back
    // as zero after reset, so it is cleared here along with the control state.
    if (reset) begin
      state     <= ST_FILL;
      idx       <= '0;
      act_vec   <= '0;
      nz_mask   <= '0;
      act_count <= '0;
    end else if (state == ST_FILL) begin
      if (accept) begin
        // NOTE: non-blocking assignments here, so idx below still reads its
        // pre-edge value when choosing the slot and computing act_count.
        for (int k = 0; k < N; k++) begin
          if (idx == IDX_W'(k)) begin
            act_vec[k*OUT_W +: OUT_W] <= q_act;
            nz_mask[k]                <= (q_act != '0);
          end
        end
        idx <= idx + 1'b1;
        if (closing) begin
          state     <= ST_EMIT;
          act_count <= idx + 1'b1;
        end
      end
    end else if (out_ready) begin
      // Vector handed over: start the next one from a clean slate.
      state     <= ST_FILL;
      idx       <= '0;
      act_vec   <= '0;
      nz_mask   <= '0;
      act_count <= '0;
    end
  end

endmodule

// File: tb/tb_neuron_act_pack.sv
// Self-checking bench for neuron_act_pack: quantiser table, directed multi-cycle
// sequences and randomized traffic scored against a behavioural model.
`timescale 1ns/1ps
module tb_neuron_act_pack;
  import aim_pkg::*;

  localparam int N     = N_FANIN;
  localparam int IN_W  = SUM_W;
  localparam int OUT_W = ACT_W;
  localparam int SHIFT = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic signed [IN_W-1:0] in_sum;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  act_vec_t               act_vec;
  logic [N-1:0]           nz_mask;
  logic [4:0]             act_count;
  logic                   out_valid;
  logic                   out_ready;

  always #5 clk = ~clk;

  neuron_act_pack #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_sum   (in_sum),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .act_vec  (act_vec),
    .nz_mask  (nz_mask),
    .act_count(act_count),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n_vec     = 0;

  typedef struct {
    act_vec_t     vec;
    logic [N-1:0] mask;
    logic [4:0]   cnt;
  } vec_t;

  typedef struct {
    int sum;
    int exp_plain;
    int exp_relu;
  } qv_t;

  vec_t exp_q[$];
  int   acc_val[N];
  int   acc_n = 0;

  task automatic check(input string name, input logic [179:0] act, input logic [179:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Reference requantiser: round(x / 2^SHIFT) with halves going up, then clamp.
  function automatic int model_quant(input int s);
    real x;
    int  r;
    x = real'(s) / (2.0 ** SHIFT) + 0.5;
    r = int'($floor(x));
    if (r > (1 << (OUT_W - 1)) - 1) r = (1 << (OUT_W - 1)) - 1;
    if (r < -(1 << (OUT_W - 1)))    r = -(1 << (OUT_W - 1));
`ifdef ACT_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  task automatic model_beat(input int s, input logic last);
    vec_t e;
    int   t;
    acc_val[acc_n] = model_quant(s);
    acc_n++;
    if (last || acc_n == N) begin
      e.vec  = '0;
      e.mask = '0;
      for (int k = 0; k < acc_n; k++) begin
        t = acc_val[k];
        e.vec[k*OUT_W +: OUT_W] = t[OUT_W-1:0];
        e.mask[k] = (t != 0);
      end
      e.cnt = 5'(acc_n);
      exp_q.push_back(e);
      acc_n = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_beat(input int s, input logic last, output int stalls);
    in_sum   = IN_W'(s);
    in_last  = last;
    in_valid = 1'b1;
    stalls   = 0;
    while (!in_ready && stalls < 64) begin
      step();
      stalls++;
    end
    if (stalls >= 64) check("beat_accept", in_ready, 1'b1);
    model_beat(s, last);
    step();
  endtask

  function automatic int rand_sum();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  // Scoreboard: every vector the consumer takes must match the model's next one.
  always begin
    vec_t e;
    @(negedge clk);
    #3;
    if (reset === 1'b0 && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        check("vec_unexpected", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sb_act_vec", act_vec, e.vec);
        check("sb_nz_mask", nz_mask, e.mask);
        check("sb_act_count", act_count, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    qv_t      tbl[14];
    act_vec_t exp_vec;
    int       e, st, stalls, v0, q;
    logic [OUT_W-1:0] e9;
    logic     acc;

    tbl[0]  = '{1000, 250, 250};
    tbl[1]  = '{1100, 255, 255};
    tbl[2]  = '{4095, 255, 255};
    tbl[3]  = '{-4096, -256, 0};
    tbl[4]  = '{-7, -2, 0};
    tbl[5]  = '{0, 0, 0};
    tbl[6]  = '{1, 0, 0};
    tbl[7]  = '{2, 1, 1};
    tbl[8]  = '{-2, 0, 0};
    tbl[9]  = '{-6, -1, 0};
    tbl[10] = '{1021, 255, 255};
    tbl[11] = '{1022, 255, 255};
    tbl[12] = '{-1022, -255, 0};
    tbl[13] = '{-1030, -256, 0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_sum    = '0;
    out_ready = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_act_vec", act_vec, '0);
    check("rst_nz_mask", nz_mask, '0);
    check("rst_act_count", act_count, '0);
    step();
    step();
    reset = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 1'b1);

    // Quantiser table, one single-beat flushed vector per record.
    foreach (tbl[i]) begin
`ifdef ACT_RELU_EN
      e = tbl[i].exp_relu;
`else
      e = tbl[i].exp_plain;
`endif
      e9 = e[OUT_W-1:0];
      send_beat(tbl[i].sum, 1'b1, st);
      check("tbl_out_valid", out_valid, 1'b1);
      check("tbl_entry0", act_vec[OUT_W-1:0], e9);
      check("tbl_count", act_count, 5'd1);
      check("tbl_mask", nz_mask, (e != 0) ? 20'h1 : 20'h0);
      in_valid = 1'b0;
    end
    step();

    // Full vector of k*40 closed by the 20th beat, not by in_last.
    exp_vec = '0;
    for (int k = 0; k < N; k++) begin
      q = k * 10;
      exp_vec[k*OUT_W +: OUT_W] = q[OUT_W-1:0];
      send_beat(k * 40, 1'b0, st);
      if (k == N - 2) check("full_no_early_valid", out_valid, 1'b0);
    end
    in_valid = 1'b0;
    check("full_out_valid", out_valid, 1'b1);
    check("full_act_vec", act_vec, exp_vec);
    check("full_nz_mask", nz_mask, 20'hFFFFE);
    check("full_act_count", act_count, 5'd20);
    step();
    check("full_valid_one_cycle", out_valid, 1'b0);
    check("full_in_ready_back", in_ready, 1'b1);

    // Partial flush after five beats.
    exp_vec = '0;
    for (int k = 0; k < 5; k++) begin
      exp_vec[k*OUT_W +: OUT_W] = 9'd100;
      send_beat(400, (k == 4), st);
    end
    in_valid = 1'b0;
    check("flush_act_count", act_count, 5'd5);
    check("flush_act_vec", act_vec, exp_vec);
    check("flush_nz_mask", nz_mask, 20'h0001F);
    step();

    // Backpressure: vector held for 10 cycles while a new beat waits.
    out_ready = 1'b0;
    exp_vec = '0;
    q = model_quant(100);  exp_vec[0*OUT_W +: OUT_W] = q[OUT_W-1:0];
    q = model_quant(-200); exp_vec[1*OUT_W +: OUT_W] = q[OUT_W-1:0];
    q = model_quant(300);  exp_vec[2*OUT_W +: OUT_W] = q[OUT_W-1:0];
    send_beat(100, 1'b0, st);
    send_beat(-200, 1'b0, st);
    send_beat(300, 1'b1, st);
    in_sum  = IN_W'(444);
    in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_act_vec", act_vec, exp_vec);
      check("bp_act_count", act_count, 5'd3);
      step();
    end
    out_ready = 1'b1;
    model_beat(444, 1'b1);
    step();
    check("bp_release_in_ready", in_ready, 1'b1);
    check("bp_release_out_valid", out_valid, 1'b0);
    step();
    in_valid = 1'b0;
    q  = 111;
    e9 = q[OUT_W-1:0];
    check("bp_next_valid", out_valid, 1'b1);
    check("bp_next_count", act_count, 5'd1);
    check("bp_next_entry0", act_vec[OUT_W-1:0], e9);
    step();

    // Reset in the middle of a fill; only the fresh beats may appear.
    for (int k = 0; k < 7; k++) send_beat(1000 + k, 1'b0, st);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_act_vec", act_vec, '0);
    check("midrst_nz_mask", nz_mask, '0);
    check("midrst_act_count", act_count, '0);
    acc_n = 0;
    exp_q.delete();
    step();
    reset = 1'b0;
    step();
    for (int k = 0; k < N; k++) send_beat(rand_sum(), 1'b0, st);
    in_valid = 1'b0;
    check("fresh_act_count", act_count, 5'd20);
    step();

    // 40 back-to-back beats: two vectors, a single in_ready gap between them.
    v0 = n_vec;
    stalls = 0;
    for (int k = 0; k < 2 * N; k++) begin
      send_beat(rand_sum(), 1'b0, st);
      stalls += st;
    end
    in_valid = 1'b0;
    step();
    check("b2b_stall_cycles", 180'(stalls), 180'(1));
    check("b2b_vectors", 180'(n_vec - v0), 180'(2));

    // Random traffic with random backpressure and random flushes.
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (acc) in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_sum   = IN_W'(rand_sum());
        in_last  = ($urandom_range(0, 7) == 0);
        in_valid = 1'b1;
      end
      acc = in_valid && in_ready;
      if (acc) model_beat(int'(in_sum), in_last);
      step();
    end
    if (acc) in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    if (acc_n > 0) send_beat(0, 1'b1, st);
    in_valid = 1'b0;
    step();
    step();
    step();
    check("drain_queue_empty", 180'(exp_q.size()), 180'(0));
    check("drain_idle", {in_ready, out_valid}, 2'b10);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
